// File: rtl/aluop_driver.sv
// aluop_driver: steps a 4-bit ALU opcode from a debounced pushbutton or an
// internal auto-step timer. After a settle delay it captures the ALU result
// onto the LEDs and compares it with a golden table. The golden values assume
// the ALU operands are tied to A=8'h22 and B=8'h11. A mismatch sets a sticky
// error flag.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a step; steps in any other state are dropped
// S_ISSUE   | one cycle: advance op (wraps after LAST_OP), clear settle count
// S_SETTLE  | let the ALU output settle for SETTLE_CYCLES cycles
// S_CAPTURE | one cycle: register result onto leds, pulse result_vld, check
module aluop_driver #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SETTLE_CYCLES   = 4,
    parameter logic [23:0] AUTO_PERIOD     = 24'd5000000,
    parameter logic [3:0]  LAST_OP         = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       auto_en,
    input  logic [7:0] alu_result,
    output logic [3:0] op,
    output logic [7:0] leds,
    output logic       result_vld,
    output logic       busy,
    output logic       err
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [15:0]     DB_LAST     = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [23:0]     AUTO_LAST   = AUTO_PERIOD - 24'd1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_SETTLE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_btn_meta;
    logic          r_btn_sync;
    logic [15:0]   r_db_cnt;
    logic          r_btn_db;
    logic          r_btn_db_d;
    logic [23:0]   r_auto_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic [3:0]    r_op;
    logic [7:0]    r_leds;
    logic          r_err;

    logic          w_btn_rise;
    logic          w_auto_tc;
    logic          w_step;
    logic          w_settle_done;
    logic          w_capture;
    logic          w_busy;
    logic [7:0]    w_gold;

    // Expected ALU output for each opcode with A=8'h22, B=8'h11.
    function automatic logic [7:0] gold_value(input logic [3:0] o);
        logic [7:0] g;
        case (o)
            4'd0:    g = 8'h33;   // A + B
            4'd1:    g = 8'h11;   // A - B
            4'd2:    g = 8'h00;   // A & B
            4'd3:    g = 8'h33;   // A | B
            4'd4:    g = 8'h33;   // A ^ B
            4'd5:    g = 8'hDD;   // ~A
            4'd6:    g = 8'h22;   // A
            4'd7:    g = 8'h23;   // A + 1
            4'd8:    g = 8'h21;   // A - 1
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debounce: follow the synced level only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_cnt   <= 16'd0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_btn_sync != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_btn_sync;
                    r_db_cnt <= 16'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= 16'd0;
            end
        end
    end

    assign w_btn_rise = r_btn_db & ~r_btn_db_d;

    // Auto-step timer: free-runs with period AUTO_PERIOD while enabled, held at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n || !auto_en) begin
            r_auto_cnt <= 24'd0;
        end else if (w_auto_tc) begin
            r_auto_cnt <= 24'd0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 24'd1;
        end
    end

    assign w_auto_tc     = auto_en & (r_auto_cnt == AUTO_LAST);
    assign w_step        = auto_en ? w_auto_tc : w_btn_rise;
    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
    assign w_gold        = gold_value(r_op);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a step outside IDLE is simply ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_step) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_settle_done) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. result_vld is masked by reset so a capture cycle that
    // coincides with reset never reports a result.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_capture = (r_state == S_CAPTURE) & rst_n;
    end

    // Opcode advance and settle counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= 4'd0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_op         <= (r_op == LAST_OP) ? 4'd0 : r_op + 4'd1;
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    if (!w_settle_done) begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_settle_cnt <= r_settle_cnt;
                end
            endcase
        end
    end

    // Result capture and sticky golden-value check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leds <= 8'h00;
            r_err  <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_leds <= alu_result;
            if (alu_result != w_gold) begin
                r_err <= 1'b1;
            end
        end
    end

    assign op         = r_op;
    assign leds       = r_leds;
    assign result_vld = w_capture;
    assign busy       = w_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_aluop_driver.sv
// Testbench for aluop_driver: directed stimulus with a queue-based scoreboard.
// Expected capture results are queued as steps are issued; an independent
// monitor pops and compares whenever result_vld pulses.
module tb_aluop_driver;

    localparam logic [15:0] DEB  = 16'd16;
    localparam int          SET  = 4;
    localparam logic [23:0] PER  = 24'd20;
    localparam logic [3:0]  LAST = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] alu_result;
    logic [3:0] op;
    logic [7:0] leds;
    logic       result_vld;
    logic       busy;
    logic       err;

    logic       force_bad = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cycle = 0;
    int         vld_count = 0;
    int         vld_times[$];

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] leds;
        logic       err;
    } exp_t;
    exp_t       exp_q[$];

    logic [3:0] exp_op = 4'd0;
    logic       exp_err = 1'b0;
    logic [7:0] gold_tbl [9] = '{8'h33, 8'h11, 8'h00, 8'h33, 8'h33, 8'hDD, 8'h22, 8'h23, 8'h21};

    aluop_driver #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET),
        .AUTO_PERIOD    (PER),
        .LAST_OP        (LAST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .auto_en   (auto_en),
        .alu_result(alu_result),
        .op        (op),
        .leds      (leds),
        .result_vld(result_vld),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // ALU model with operands A=8'h22, B=8'h11.
    always_comb begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        a = 8'h22;
        b = 8'h11;
        m = 8'h00;
        case (op)
            4'd0: m = a + b;
            4'd1: m = a - b;
            4'd2: m = a & b;
            4'd3: m = a | b;
            4'd4: m = a ^ b;
            4'd5: m = ~a;
            4'd6: m = a;
            4'd7: m = a + 8'd1;
            4'd8: m = a - 8'd1;
            default: m = 8'h00;
        endcase
        alu_result = (force_bad && op == 4'd3) ? 8'hFF : m;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_next(input logic bad);
        exp_t e;
        exp_op = (exp_op == LAST) ? 4'd0 : exp_op + 4'd1;
        if (bad) exp_err = 1'b1;
        e.op   = exp_op;
        e.leds = bad ? 8'hFF : gold_tbl[exp_op];
        e.err  = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic press();
        btn = 1'b1;
        tick(40);
        btn = 1'b0;
        tick(40);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        tick(2);
    endtask

    // Scoreboard monitor: leds/err update at the edge that ends the result_vld cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_vld === 1'b1) begin
                vld_count++;
                vld_times.push_back(cycle);
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_capture: op=%0h leds=%02h, required no capture", op, leds);
                end else begin
                    e = exp_q.pop_front();
                    check("cap_op", op, e.op);
                    check("cap_leds", leds, e.leds);
                    check("cap_err", err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int n2;
        int v0;
        int d;
        int press_lat;
        int auto_lat;
        logic [3:0] op0;

        // Reset values.
        rst_n = 1'b0;
        tick(5);
        check("rst_op", op, 0);
        check("rst_leds", leds, 8'h00);
        check("rst_vld", result_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick(3);

        // Test 1: nine clean presses, opcode wraps 8 -> 0; first press checks latency.
        expect_next(1'b0);
        btn = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("t1_busy_rise", busy, 1);
        press_lat = n;
        check("t1_op_at_issue", op, 0);
        n2 = 0;
        while (result_vld !== 1'b1 && n2 < 50) begin
            tick(1);
            n2++;
        end
        check("t1_busy_to_vld", n2, SET + 1);
        tick(20);
        btn = 1'b0;
        tick(40);
        for (int i = 1; i < 9; i++) begin
            expect_next(1'b0);
            press();
        end
        wait_drain("t1_drain", 200);
        check("t1_op_wrapped", op, 0);
        check("t1_err", err, 0);
        check("t1_busy_idle", busy, 0);

        // Test 2: bouncing button produces exactly one step.
        v0 = vld_count;
        expect_next(1'b0);
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            tick(10);
        end
        btn = 1'b1;
        tick(60);
        btn = 1'b0;
        tick(40);
        wait_drain("t2_drain", 200);
        check("t2_one_capture", vld_count - v0, 1);
        check("t2_op", op, 1);

        // Test 3: auto mode, one capture every AUTO_PERIOD cycles, button ignored.
        v0 = vld_count;
        vld_times.delete();
        for (int i = 0; i < 9; i++) expect_next(1'b0);
        auto_en = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("t3_busy_rise", busy, 1);
        auto_lat = n;
        btn = 1'b1;
        tick(40);
        btn = 1'b0;
        tick(40);
        wait_drain("t3_drain", 400);
        auto_en = 1'b0;
        check("t3_captures", vld_count - v0, 9);
        check("t3_stamp_count", vld_times.size(), 9);
        for (int i = 1; i < vld_times.size(); i++) begin
            check("t3_period", vld_times[i] - vld_times[i-1], PER);
        end
        tick(60);
        check("t3_stopped", vld_count - v0, 9);
        check("t3_op", op, 1);

        // Test 4: corrupt result at op=3 sets err; err stays set afterwards.
        expect_next(1'b0);
        press();
        force_bad = 1'b1;
        expect_next(1'b1);
        press();
        force_bad = 1'b0;
        expect_next(1'b0);
        press();
        expect_next(1'b0);
        press();
        wait_drain("t4_drain", 200);
        check("t4_err_sticky", err, 1);
        check("t4_op", op, 5);

        // Test 5: button step one cycle after a timer step is dropped.
        v0 = vld_count;
        op0 = op;
        expect_next(1'b0);
        d = auto_lat - press_lat + 1;
        if (d >= 0) begin
            auto_en = 1'b1;
            if (d > 0) tick(d);
            btn = 1'b1;
        end else begin
            btn = 1'b1;
            tick(-d);
            auto_en = 1'b1;
        end
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        auto_en = 1'b0;
        check("t5_busy_rise", busy, 1);
        tick(40);
        btn = 1'b0;
        tick(40);
        wait_drain("t5_drain", 200);
        check("t5_one_capture", vld_count - v0, 1);
        check("t5_op_plus1", op, op0 + 4'd1);

        // Test 6: reset during SETTLE abandons the step.
        v0 = vld_count;
        btn = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("t6_busy_rise", busy, 1);
        tick(2);
        check("t6_err_before", err, 1);
        btn = 1'b0;
        rst_n = 1'b0;
        tick(1);
        check("t6_op", op, 0);
        check("t6_leds", leds, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_vld", result_vld, 0);
        check("t6_err", err, 0);
        rst_n = 1'b1;
        tick(40);
        check("t6_no_capture", vld_count - v0, 0);
        check("t6_leds_hold", leds, 8'h00);
        check("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
